// File: rtl/bcd_updown_counter.sv
// Multi-digit modulo-RADIX up/down counter with clear, parallel load, count
// enable, combinational terminal-count cascade output and sticky ovf/err flags.
module bcd_updown_counter #(
  parameter int DIGITS = 2,
  parameter int RADIX  = 10
) (
  input  logic                  clk,
  input  logic                  r,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  ovf,
  output logic                  err
);

  localparam logic [4:0] RADIX_V = 5'(RADIX);
  localparam logic [3:0] MAX_D   = 4'(RADIX - 1);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;

  logic [4*DIGITS-1:0] step_s;
  logic [4*DIGITS-1:0] ld_val_s;
  logic [DIGITS-1:0]   ld_bad_s;
  logic [DIGITS:0]     carry_s;
  logic [DIGITS:0]     borrow_s;
  logic                wrap_s;

  assign carry_s[0]  = 1'b1;
  assign borrow_s[0] = 1'b1;

  // carry_s[i] / borrow_s[i]: every digit below i is at max / at zero.
  // Digits holding an illegal value (>= RADIX) count as max so they wrap to 0.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] cur_s, inc_s, dec_s, din_s;
    logic       at_max_s, at_zero_s, illegal_s;

    assign cur_s     = count_q[4*i +: 4];
    assign din_s     = din[4*i +: 4];
    assign at_max_s  = ({1'b0, cur_s} >= (RADIX_V - 5'd1));
    assign at_zero_s = (cur_s == 4'd0);
    assign illegal_s = ({1'b0, cur_s} >= RADIX_V);

    assign carry_s[i+1]  = carry_s[i] & at_max_s;
    assign borrow_s[i+1] = borrow_s[i] & at_zero_s;

    assign inc_s = at_max_s  ? 4'd0  : (cur_s + 4'd1);
    assign dec_s = at_zero_s ? MAX_D : (illegal_s ? (MAX_D - 4'd1) : (cur_s - 4'd1));

    assign step_s[4*i +: 4] = up ? (carry_s[i]  ? inc_s : cur_s)
                                 : (borrow_s[i] ? dec_s : cur_s);

    assign ld_bad_s[i]        = ({1'b0, din_s} >= RADIX_V);
    assign ld_val_s[4*i +: 4] = ld_bad_s[i] ? 4'd0 : din_s;
  end

  assign wrap_s = en & (up ? carry_s[DIGITS] : borrow_s[DIGITS]);
  assign tc     = wrap_s & ~clr & ~load;

  // Next-state selection: clr > load > en > hold.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
      err_d   = 1'b0;
    end else if (load) begin
      count_d = ld_val_s;
      err_d   = err_q | (|ld_bad_s);
    end else if (en) begin
      count_d = step_s;
      ovf_d   = ovf_q | wrap_s;
    end else begin
      count_d = count_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign q   = count_q;
  assign ovf = ovf_q;
  assign err = err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed self-checking bench: main 2-digit BCD counter, a cascaded pair,
// and a single-digit radix-16 instance.
module tb_bcd_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r;
  logic       en, up, clr, load;
  logic [7:0] din, q;
  logic       tc, ovf, err;

  logic       en_c, clr_c;
  logic [7:0] qa, qb;
  logic       tca, tcb, ovfa, ovfb, erra, errb;

  logic       en_h, clr_h, load_h;
  logic [3:0] din_h, q_h;
  logic       tc_h, ovf_h, err_h;

  int checks = 0;
  int errors = 0;

  bcd_updown_counter #(.DIGITS(2), .RADIX(10)) u_dut (
    .clk(clk), .r(r), .en(en), .up(up), .clr(clr), .load(load),
    .din(din), .q(q), .tc(tc), .ovf(ovf), .err(err)
  );

  bcd_updown_counter #(.DIGITS(2), .RADIX(10)) u_lo (
    .clk(clk), .r(r), .en(en_c), .up(1'b1), .clr(clr_c), .load(1'b0),
    .din(8'h00), .q(qa), .tc(tca), .ovf(ovfa), .err(erra)
  );

  bcd_updown_counter #(.DIGITS(2), .RADIX(10)) u_hi (
    .clk(clk), .r(r), .en(tca), .up(1'b1), .clr(clr_c), .load(1'b0),
    .din(8'h00), .q(qb), .tc(tcb), .ovf(ovfb), .err(errb)
  );

  bcd_updown_counter #(.DIGITS(1), .RADIX(16)) u_hex (
    .clk(clk), .r(r), .en(en_h), .up(1'b1), .clr(clr_h), .load(load_h),
    .din(din_h), .q(q_h), .tc(tc_h), .ovf(ovf_h), .err(err_h)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    r = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; din = 8'h00;
    en_c = 1'b0; clr_c = 1'b0;
    en_h = 1'b0; clr_h = 1'b0; load_h = 1'b0; din_h = 4'h0;
    tick(2);
    check("reset_q", q, 8'h00);
    check("reset_ovf", ovf, 1'b0);
    check("reset_err", err, 1'b0);
    r = 1'b0;

    // 1: async reset mid-run, then count up 12
    din = 8'h37; load = 1'b1; tick(1); load = 1'b0;
    check("t1_load37", q, 8'h37);
    #2 r = 1'b1;
    #1;
    check("t1_async_q", q, 8'h00);
    check("t1_async_ovf", ovf, 1'b0);
    check("t1_async_err", err, 1'b0);
    r = 1'b0;
    en = 1'b1; up = 1'b1;
    tick(12);
    check("t1_up12", q, 8'h12);
    en = 1'b0;

    // 2: up wrap from 99
    din = 8'h98; load = 1'b1; tick(1); load = 1'b0;
    check("t2_load98", q, 8'h98);
    en = 1'b1; up = 1'b1;
    tick(1);
    check("t2_q99", q, 8'h99);
    check("t2_tc", tc, 1'b1);
    load = 1'b1; #1;
    check("t2_tc_load", tc, 1'b0);
    load = 1'b0; #1;
    tick(1);
    check("t2_wrap_q", q, 8'h00);
    check("t2_wrap_ovf", ovf, 1'b1);
    tick(5);
    check("t2_q05", q, 8'h05);
    check("t2_ovf_sticky", ovf, 1'b1);
    en = 1'b0;

    // 3: down wrap from 00
    clr = 1'b1; tick(1); clr = 1'b0;
    check("t3_clr_q", q, 8'h00);
    check("t3_clr_ovf", ovf, 1'b0);
    en = 1'b1; up = 1'b0; #1;
    check("t3_tc", tc, 1'b1);
    tick(1);
    check("t3_q99", q, 8'h99);
    check("t3_ovf", ovf, 1'b1);
    tick(1);
    check("t3_q98", q, 8'h98);
    check("t3_tc0", tc, 1'b0);
    en = 1'b0;

    // 4: illegal load, clear, clr priority
    din = 8'h3C; load = 1'b1; tick(1); load = 1'b0;
    check("t4_q30", q, 8'h30);
    check("t4_err", err, 1'b1);
    clr = 1'b1; tick(1); clr = 1'b0;
    check("t4_clr_q", q, 8'h00);
    check("t4_clr_err", err, 1'b0);
    check("t4_clr_ovf", ovf, 1'b0);
    din = 8'h45; load = 1'b1; tick(1);
    check("t4_q45", q, 8'h45);
    clr = 1'b1; en = 1'b1; up = 1'b1; tick(1);
    check("t4_clr_wins", q, 8'h00);
    clr = 1'b0; load = 1'b0; en = 1'b0;

    // 5: cascade 250 edges
    clr_c = 1'b1; tick(1); clr_c = 1'b0;
    en_c = 1'b1;
    tick(250);
    en_c = 1'b0;
    check("t5_lo", qa, 8'h50);
    check("t5_hi", qb, 8'h02);
    check("t5_hi_ovf", ovfb, 1'b0);

    // 6: radix-16 single digit
    clr_h = 1'b1; tick(1); clr_h = 1'b0;
    en_h = 1'b1;
    tick(17);
    en_h = 1'b0;
    check("t6_q1", q_h, 4'h1);
    check("t6_ovf", ovf_h, 1'b1);
    din_h = 4'hF; load_h = 1'b1; tick(1); load_h = 1'b0;
    check("t6_qF", q_h, 4'hF);
    check("t6_err", err_h, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
